// File: rtl/prog_loader.sv
`default_nettype none
// ==== prog_loader : byte-stream program loader (len, big-endian words, XOR csum) ====
// ==== Revision 1.0                                                               ====
module prog_loader #(
  parameter int BITNESS = 16,
  parameter int DEPTH   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [BITNESS-1:0] pc,
  output logic [15:0]        ins,
  output logic               cpu_rst,
  output logic               loaded,
  output logic               err,
  output logic [10:0]        words
);

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CSUM    = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  csum_q, csum_d;
  logic [9:0]  waddr_q, waddr_d;
  logic [10:0] words_q, words_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        loaded_q, loaded_d;
  logic        err_q, err_d;

  logic        accept;
  logic        wr_en;
  logic [15:0] len_new;
  logic [10:0] words_inc;
  logic [9:0]  rd_idx;
  logic        unused_pc;

  logic [15:0] mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hi_d      = hi_q;
    csum_d    = csum_q;
    waddr_d   = waddr_q;
    words_d   = words_q;
    wr_en     = 1'b0;
    len_new   = {len_q[15:8], rx_data};
    words_inc = words_q + 11'd1;
    rx_ready  = rst && (state_q != RUN) && (state_q != ERROR);
    accept    = rx_valid && rx_ready;

    if (accept) begin
      case (state_q)
        LEN_HI: begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = len_new;
          if ((len_new == 16'd0) || (32'(len_new) > 32'(DEPTH))) state_d = ERROR;
          else                                                    state_d = DATA_HI;
        end
        DATA_HI: begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          wr_en   = 1'b1;
          csum_d  = csum_q ^ rx_data;
          waddr_d = waddr_q + 10'd1;
          words_d = words_inc;
          // len is at most DEPTH here, so words stops exactly at len
          if ({5'd0, words_inc} == len_q) state_d = CSUM;
          else                            state_d = DATA_HI;
        end
        CSUM: begin
          if (rx_data == csum_q) state_d = RUN;
          else                   state_d = ERROR;
        end
        default: state_d = state_q;
      endcase
    end

    cpu_rst_d = (state_d != RUN);
    loaded_d  = (state_d == RUN);
    err_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LEN_HI;
      len_q     <= 16'd0;
      hi_q      <= 8'd0;
      csum_q    <= 8'd0;
      waddr_q   <= 10'd0;
      words_q   <= 11'd0;
      cpu_rst_q <= 1'b1;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      csum_q    <= csum_d;
      waddr_q   <= waddr_d;
      words_q   <= words_d;
      cpu_rst_q <= cpu_rst_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
    end
  end

  // Instruction memory is deliberately left unreset; reads are masked by len/state.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr_q] <= {hi_q, rx_data};
  end

  assign rd_idx    = pc[9:0];
  assign unused_pc = ^pc;

  always_comb begin
    ins = 16'h0000;
    if ((state_q == RUN) && ({6'd0, rd_idx} < len_q)) ins = mem[rd_idx];
  end

  assign cpu_rst = cpu_rst_q;
  assign loaded  = loaded_q;
  assign err     = err_q;
  assign words   = words_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ==== tb_prog_loader : randomized + directed checks of prog_loader against a stream model ====
// ==== Revision 1.0                                                                        ====
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] pc;
  logic [15:0] ins;
  logic        cpu_rst;
  logic        loaded;
  logic        err;
  logic [10:0] words;

  int total = 0;
  int bad   = 0;

  // Reference model state: bytes the loader should have taken, and what they imply.
  byte unsigned sent[$];
  byte unsigned img[$];
  int  exp_len;
  int  exp_words;
  bit  exp_loaded;
  bit  exp_err;
  int  exp_mem[1024];

  prog_loader #(.BITNESS(16), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pc(pc), .ins(ins), .cpu_rst(cpu_rst), .loaded(loaded), .err(err), .words(words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Interpret the accepted byte stream from the protocol rules directly.
  task automatic model();
    int n;
    int cs;
    n          = sent.size();
    exp_loaded = 1'b0;
    exp_err    = 1'b0;
    exp_words  = 0;
    exp_len    = 0;
    if (n >= 1) exp_len = int'(sent[0]) * 256;
    if (n < 2) return;
    exp_len = int'(sent[0]) * 256 + int'(sent[1]);
    if (exp_len == 0 || exp_len > 1024) begin
      exp_err = 1'b1;
      return;
    end
    exp_words = (n - 2) / 2;
    if (exp_words > exp_len) exp_words = exp_len;
    for (int i = 0; i < exp_words; i++)
      exp_mem[i] = int'(sent[2 + 2*i]) * 256 + int'(sent[3 + 2*i]);
    if (n > 2 + 2*exp_len) begin
      cs = 0;
      for (int i = 2; i < 2 + 2*exp_len; i++) cs = cs ^ int'(sent[i]);
      if (int'(sent[2 + 2*exp_len]) == cs) exp_loaded = 1'b1;
      else                                 exp_err    = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    if (!exp_loaded && !exp_err) sent.push_back(b);
    model();
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".words"},    32'(words),    32'(exp_words));
    chk({tag, ".loaded"},   32'(loaded),   32'(exp_loaded));
    chk({tag, ".err"},      32'(err),      32'(exp_err));
    chk({tag, ".cpu_rst"},  32'(cpu_rst),  32'(!exp_loaded));
    chk({tag, ".rx_ready"}, 32'(rx_ready), 32'(!exp_loaded && !exp_err));
  endtask

  task automatic check_ins(input string tag, input logic [15:0] pcv);
    int idx;
    int e;
    pc  = pcv;
    #1;
    idx = int'(pcv) % 1024;
    e   = (exp_loaded && idx < exp_len) ? exp_mem[idx] : 0;
    chk({tag, ".ins"}, 32'(ins), 32'(e));
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    sent.delete();
    model();
    #2;
    chk({tag, ".rst.words"},    32'(words),    32'd0);
    chk({tag, ".rst.loaded"},   32'(loaded),   32'd0);
    chk({tag, ".rst.err"},      32'(err),      32'd0);
    chk({tag, ".rst.cpu_rst"},  32'(cpu_rst),  32'd1);
    chk({tag, ".rst.rx_ready"}, 32'(rx_ready), 32'd0);
    check_ins({tag, ".rst"}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_img(input string tag, input int maxgap, input bit each);
    foreach (img[i]) begin
      send_byte(img[i], maxgap);
      if (each) check_status(tag);
    end
  endtask

  task automatic build_image(input int len, input bit good, input bit idx_data);
    int cs;
    logic [15:0] w;
    img.delete();
    img.push_back(8'(len >> 8));
    img.push_back(8'(len));
    cs = 0;
    for (int i = 0; i < len; i++) begin
      w = idx_data ? 16'(i) : 16'($urandom);
      img.push_back(w[15:8]);
      img.push_back(w[7:0]);
      cs = cs ^ int'(w[15:8]) ^ int'(w[7:0]);
    end
    if (!good) cs = cs ^ (1 << $urandom_range(7, 0));
    img.push_back(8'(cs));
  endtask

  task automatic load_ref(input logic [7:0] last);
    img = '{8'h00, 8'h03, 8'h20, 8'h6F, 8'h20, 8'h6F, 8'h6F, 8'h20, 8'h00};
    img[8] = last;
  endtask

  task automatic ref_ins_consts(input string tag);
    pc = 16'd0; #1; chk({tag, ".pc0"}, 32'(ins), 32'h206F);
    pc = 16'd1; #1; chk({tag, ".pc1"}, 32'(ins), 32'h206F);
    pc = 16'd2; #1; chk({tag, ".pc2"}, 32'(ins), 32'h6F20);
    pc = 16'd3; #1; chk({tag, ".pc3"}, 32'(ins), 32'h0000);
    chk({tag, ".words3"}, 32'(words), 32'd3);
  endtask

  initial begin
    int len;
    bit good;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    pc       = 16'h0000;
    model();

    // Reference image, continuous valid
    reset_dut("init");
    load_ref(8'h4F);
    send_img("ref", 0, 1'b1);
    ref_ins_consts("ref");
    for (int i = 0; i < 6; i++) check_ins("ref", 16'(i));
    check_ins("ref.wrap", 16'hFC01);
    send_byte(8'h55, 0);
    send_byte(8'hAA, 2);
    check_status("ref.after");

    // Bad checksum
    reset_dut("bcs");
    load_ref(8'h4E);
    send_img("bcs", 0, 1'b1);
    chk("bcs.err", 32'(err), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h4F, 0);
    check_status("bcs.after");
    check_ins("bcs", 16'h0000);
    check_ins("bcs", 16'h0002);

    // Illegal lengths: error decided on the LEN_LO byte
    reset_dut("len0");
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("len0.err", 32'(err), 32'd1);
    chk("len0.words", 32'(words), 32'd0);
    send_byte(8'h12, 0);
    check_status("len0");
    reset_dut("len401");
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    chk("len401.err", 32'(err), 32'd1);
    chk("len401.words", 32'(words), 32'd0);
    check_status("len401");

    // Gapped valid
    reset_dut("gap");
    load_ref(8'h4F);
    send_img("gap", 5, 1'b1);
    ref_ins_consts("gap");

    // Async reset after two words, then full reload
    reset_dut("abort");
    load_ref(8'h4F);
    for (int i = 0; i < 6; i++) send_byte(img[i], 0);
    check_status("abort.pre");
    chk("abort.words2", 32'(words), 32'd2);
    reset_dut("abort");
    send_img("abort.reload", 0, 1'b1);
    ref_ins_consts("abort.reload");

    // Randomized images
    for (int t = 0; t < 8; t++) begin
      reset_dut("rnd");
      len  = int'($urandom_range(48, 1));
      good = ($urandom_range(3, 0) != 0);
      build_image(len, good, 1'b0);
      send_img("rnd", 3, 1'b1);
      check_ins("rnd", 16'd0);
      check_ins("rnd", 16'(len - 1));
      check_ins("rnd", 16'(len));
      for (int k = 0; k < 6; k++) check_ins("rnd", 16'($urandom));
    end
    reset_dut("rndlen");
    send_byte(8'($urandom_range(255, 5)), 1);
    send_byte(8'($urandom), 1);
    check_status("rndlen");

    // Full-depth image, word i = i
    reset_dut("full");
    build_image(1024, 1'b1, 1'b1);
    send_img("full", 0, 1'b0);
    check_status("full");
    pc = 16'h03FF; #1; chk("full.pc3ff", 32'(ins), 32'h03FF);
    pc = 16'h0400; #1; chk("full.pc400", 32'(ins), 32'h0000);
    check_ins("full", 16'h0001);
    check_ins("full", 16'h1234);
    for (int k = 0; k < 6; k++) check_ins("full", 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
